// File: rtl/dmem_responder_cache.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder_cache
//  Description : Direct-mapped, write-back, write-allocate data cache sitting
//                between the CPU data port (mem_*) and a 256-bit line-granular
//                physical memory port (pmem_*). One 32-byte line per set;
//                valid/dirty/tag/data are kept in flops and read
//                combinationally so hits complete in the request cycle.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              in    clock
//    rst              in    asynchronous active-high reset
//    mem_read         in    CPU load request, held until mem_resp
//    mem_write        in    CPU store request, held until mem_resp
//    mem_byte_enable  in    store byte mask (bit i -> byte i of the word)
//    mem_address      in    byte address, bits [1:0] ignored
//    mem_wdata        in    store data
//    mem_resp         out   one-cycle completion pulse
//    mem_rdata        out   load data, valid while mem_resp = 1
//    pmem_read        out   line fill request, held until pmem_resp
//    pmem_write       out   line writeback request, held until pmem_resp
//    pmem_address     out   line-aligned address
//    pmem_wdata       out   victim line data
//    pmem_resp        in    downstream completion pulse
//    pmem_rdata       in    fill line, valid with pmem_resp
// ============================================================================
module dmem_responder_cache #(
    parameter int s_index  = 4,
    parameter int s_offset = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_byte_enable,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    output logic         mem_resp,
    output logic [31:0]  mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [255:0] pmem_rdata
);

    localparam int NUM_SETS = 2 ** s_index;
    localparam int TAG_W    = 32 - s_offset - s_index;
    localparam int LINE_W   = 8 << s_offset;
    localparam int WORD_W   = s_offset - 2;

    typedef enum logic [1:0] {
        S_CHECK     = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    state_t state;

    // Per-set bookkeeping. valid/dirty need reset; tag/data never do because
    // they are only ever looked at through a set valid bit.
    logic [NUM_SETS-1:0] valid;
    logic [NUM_SETS-1:0] dirty;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [LINE_W-1:0]   line_q [NUM_SETS];

    // Tag/index of the request that missed. Captured at the miss so the
    // downstream transaction stays stable even if the CPU misbehaves and
    // changes or drops its request mid-miss.
    logic [TAG_W-1:0]    miss_tag;
    logic [s_index-1:0]  miss_idx;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic [TAG_W-1:0]    req_tag;
    logic [s_index-1:0]  req_idx;
    logic [WORD_W-1:0]   req_word;
    logic [s_offset+2:0] word_base;   // bit position of the word in the line
    logic                req;
    logic                lookup_hit;
    logic                hit;
    logic                store_hit;
    logic                fill;
    logic [31:0]         cur_word;
    logic [31:0]         be_mask;
    logic [31:0]         merged_word;
    logic                unused_addr_bits;

    assign req_tag   = mem_address[31 -: TAG_W];
    assign req_idx   = mem_address[s_offset +: s_index];
    assign req_word  = mem_address[s_offset-1:2];
    assign word_base = {req_word, 5'b00000};
    assign req       = mem_read | mem_write;

    // Word addressing makes the two low address bits meaningless here.
    assign unused_addr_bits = ^mem_address[1:0];

    assign lookup_hit = valid[req_idx] && (tag_q[req_idx] == req_tag);
    assign hit        = (state == S_CHECK) && req && lookup_hit;
    // A simultaneous read+write is handled as a store; the load data still
    // shows the word as it was before the merge.
    assign store_hit  = hit && mem_write;
    assign fill       = (state == S_ALLOCATE) && pmem_resp;

    assign cur_word    = line_q[req_idx][word_base +: 32];
    assign be_mask     = {{8{mem_byte_enable[3]}}, {8{mem_byte_enable[2]}},
                          {8{mem_byte_enable[1]}}, {8{mem_byte_enable[0]}}};
    assign merged_word = (cur_word & ~be_mask) | (mem_wdata & be_mask);

    // The CPU-side response is combinational so that hits complete in the
    // same cycle they are presented. Since hit is qualified by S_CHECK,
    // mem_resp can never rise during a writeback or fill.
    assign mem_resp  = hit;
    assign mem_rdata = hit ? cur_word : 32'd0;

    // ------------------------------------------------------------------------
    // Control FSM with registered pmem outputs. The async reset clears the
    // pmem strobes immediately, and returning to S_CHECK means a late
    // pmem_resp from the abandoned transaction falls on a state that ignores it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_CHECK;
            valid        <= '0;
            dirty        <= '0;
            miss_tag     <= '0;
            miss_idx     <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= 32'd0;
            pmem_wdata   <= '0;
        end else begin
            case (state)
                S_CHECK: begin
                    if (req) begin
                        if (lookup_hit) begin
                            // A store marks the line dirty even with an
                            // all-zero byte mask.
                            if (mem_write) begin
                                dirty[req_idx] <= 1'b1;
                            end
                        end else begin
                            miss_tag <= req_tag;
                            miss_idx <= req_idx;
                            if (valid[req_idx] && dirty[req_idx]) begin
                                state        <= S_WRITEBACK;
                                pmem_write   <= 1'b1;
                                pmem_address <= {tag_q[req_idx], req_idx,
                                                 {s_offset{1'b0}}};
                                pmem_wdata   <= line_q[req_idx];
                            end else begin
                                state        <= S_ALLOCATE;
                                pmem_read    <= 1'b1;
                                pmem_address <= {req_tag, req_idx,
                                                 {s_offset{1'b0}}};
                            end
                        end
                    end
                end

                S_WRITEBACK: begin
                    if (pmem_resp) begin
                        dirty[miss_idx] <= 1'b0;
                        state           <= S_ALLOCATE;
                        pmem_write      <= 1'b0;
                        pmem_read       <= 1'b1;
                        pmem_address    <= {miss_tag, miss_idx,
                                            {s_offset{1'b0}}};
                        pmem_wdata      <= '0;
                    end
                end

                S_ALLOCATE: begin
                    if (pmem_resp) begin
                        valid[miss_idx] <= 1'b1;
                        dirty[miss_idx] <= 1'b0;
                        state           <= S_CHECK;
                        pmem_read       <= 1'b0;
                        pmem_address    <= 32'd0;
                    end
                end

                default: begin
                    state      <= S_CHECK;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Tag and line storage. A fill and a store hit are mutually exclusive
    // because they belong to different FSM states.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (fill) begin
            line_q[miss_idx] <= pmem_rdata;
            tag_q[miss_idx]  <= miss_tag;
        end else if (store_hit) begin
            line_q[req_idx][word_base +: 32] <= merged_word;
        end
    end

endmodule
`default_nettype wire
